// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  // FETCH: normal operation. DROP: the outstanding response belongs to a
  // path abandoned by a redirect and is discarded when it arrives.
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // One buffered instruction word and the address it was fetched from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fifo_entry_t;

  // Clear the byte-offset bits of an address.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry FIFO of {instr, pc}. slot0 is always the head; outputs are
// register-only so the consumer sees no combinational path from memory.
module fetch_fifo2
  import fetch_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fifo_entry_t din,
  output fifo_entry_t head,
  output logic [1:0]  count
);

  fifo_entry_t slot0;
  fifo_entry_t slot1;
  logic        pop_ok;
  logic        push_ok;

  // Guard against popping an empty FIFO or pushing into a full one.
  always_comb begin
    pop_ok  = pop && (count != 2'd0);
    push_ok = push && ((count != 2'd2) || pop_ok);
  end

  // Storage and occupancy; flush wins over push/pop.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) slot0 <= din;
          else               slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = slot0;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch PC, single-outstanding memory request,
// 2-entry return buffer, and redirect handling feeding the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = fetch_pkg::DEFAULT_RESET_PC
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        IFIDWrite,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        ImReq,
  output logic [31:0] ImAddr,
  input  logic        ImAck,
  input  logic [31:0] ImData,
  output logic [31:0] Instruction,
  output logic [31:0] PC
);

  import fetch_pkg::*;

  fetch_state_e state;
  fetch_state_e state_nxt;
  logic [31:0]  fpc;
  logic [31:0]  fpc_nxt;
  logic         req_nxt;
  logic [31:0]  addr_nxt;

  logic         done;
  logic         hold;
  logic         push;
  logic         pop;
  logic [1:0]   count;
  logic [1:0]   count_nxt;
  fifo_entry_t  din;
  fifo_entry_t  head;

  // Handshake decode and FIFO control for this edge.
  always_comb begin
    done      = ImReq && ImAck;
    hold      = ImReq && !ImAck;
    push      = done && (state == FETCH) && !Redirect;
    pop       = (count != 2'd0) && !IFIDWrite;
    din.instr = ImData;
    din.pc    = ImAddr;
    if (Redirect) count_nxt = 2'd0;
    else          count_nxt = count + 2'(push) - 2'(pop);
  end

  fetch_fifo2 u_fifo (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (Redirect),
    .din     (din),
    .head    (head),
    .count   (count)
  );

  // Next state, fetch pointer and next request.
  // A held request keeps its address even across a redirect; the new
  // target is only issued once the old transfer has completed.
  always_comb begin
    state_nxt = state;
    fpc_nxt   = fpc;
    req_nxt   = 1'b0;
    addr_nxt  = ImAddr;

    case (state)
      FETCH:   if (Redirect && hold) state_nxt = DROP;
      DROP:    if (done)             state_nxt = FETCH;
      default:                       state_nxt = FETCH;
    endcase

    if (Redirect)  fpc_nxt = word_align(RedirectPC);
    else if (push) fpc_nxt = fpc + 32'd4;

    if (hold) begin
      req_nxt  = 1'b1;
      addr_nxt = ImAddr;
    end else begin
      req_nxt  = (count_nxt < 2'd2) && (state_nxt != DROP);
      addr_nxt = fpc_nxt;
    end
  end

  // State, fetch pointer and registered memory request.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= FETCH;
      fpc    <= RESET_PC;
      ImReq  <= 1'b0;
      ImAddr <= RESET_PC;
    end else begin
      state  <= state_nxt;
      fpc    <= fpc_nxt;
      ImReq  <= req_nxt;
      ImAddr <= addr_nxt;
    end
  end

  // IF/ID sees the buffer head, or a bubble when the buffer is empty.
  always_comb begin
    if (count != 2'd0) begin
      Instruction = head.instr;
      PC          = head.pc;
    end else begin
      Instruction = NOP_INSTR;
      PC          = 32'h0;
    end
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage: owns the fetch PC, issues instruction-memory reads over a req/ack handshake, buffers returned words in a 2-entry FIFO, and drives the IF/ID pipeline register (`InstructionIn`, `PC`) under that register's stall convention. It sits between instruction memory and FR_IF_ID and accepts branch/jump redirects from ID.

## Interface
- `RESET_PC`, default 32'h0000_3000: first fetch address after reset.
- `Clk`  in  1  sole clock, rising edge.
- `Reset_n`  in  1  reset, asynchronous, active-low.
- `IFIDWrite`  in  1  stall from hazard unit; 1 = IF/ID holds (no consume), 0 = IF/ID captures this edge.
- `Redirect`  in  1  taken branch/jump from ID.
- `RedirectPC`  in  32  target address; bits [1:0] ignored (forced 00).
- `ImReq`  out  1  read request to instruction memory (registered).
- `ImAddr`  out  32  read address, word-aligned (registered).
- `ImAck`  in  1  memory accepts request; `ImData` valid in same cycle.
- `ImData`  in  32  instruction word.
- `Instruction`  out  32  to FR_IF_ID `InstructionIn`; FIFO head, or NOP 32'h0 when empty.
- `PC`  out  32  to FR_IF_ID `PC`; address of head word, 32'h0 when empty (IF/ID adds 4).

## Operation
- FSM states: FETCH (normal), DROP (redirect hit while request outstanding; discard its response).
- Memory protocol: one outstanding request. Once `ImReq`=1, `ImReq`/`ImAddr` stay stable until the edge where `ImAck`=1. The transfer completes at that edge.
- Fetch pointer `fpc`: advances by 4 on each completed non-discarded transfer. It wraps modulo 2^32.
- FIFO entry = {instr, pc}. A push occurs on ack in FETCH. A pop (consume) occurs on an edge with count>0 and `IFIDWrite`=0.
- Next request: `ImReq` is registered high for the next cycle iff count_next + 0 < 2 and the FSM is not entering or staying in DROP with its response pending. count_next includes this edge's push and pop. The FIFO therefore never overflows.
- Empty FIFO with `IFIDWrite`=0: IF/ID captures NOP (bubble). This is legal and is not an error.
- Redirect, sampled at the edge, has the highest priority:
  - FIFO flushed (count←0), except a pop at the same edge still counts as delivered.
  - `fpc`←{RedirectPC[31:2],2'b00}.
  - If a request is outstanding and `ImAck`=0: go to DROP. The old `ImReq`/`ImAddr` are held until ack, the data is discarded, then FETCH issues `RedirectPC`.
  - If `ImAck`=1 at the same edge: that data is discarded, stay in FETCH, and request `RedirectPC` next cycle.
  - Redirect while in DROP: update `fpc` only and remain in DROP.
- No delay-slot preservation: ID asserts `Redirect` only after the slot instruction has been consumed.
- Reset (async, any time, including mid-transfer):
  - `ImReq`=0, `ImAddr`=`RESET_PC`, `fpc`=`RESET_PC`.
  - FIFO empty, so `Instruction`=0 and `PC`=0.
  - FSM state = FETCH.
  - A pending memory transfer is abandoned; memory must tolerate a dropped request.

## Timing
- `ImReq` rises at the first `Clk` edge after `Reset_n` deasserts.
- With a zero-wait memory (ack in the first request cycle), the first instruction appears on `Instruction` 2 edges after reset release.
- Sustained throughput is 1 word/cycle.
- Ack-to-output latency: 1 edge (FIFO is registered; outputs read the head combinationally from registers only).
- `Instruction`/`PC` are stable throughout any `IFIDWrite`=1 period unless `Redirect` fires.
- Redirect-to-target-visible: 2 edges minimum with zero-wait memory, plus the remaining wait cycles of any dropped transfer.

## Structure
- Shared package `fetch_pkg`: FSM state enum (FETCH, DROP), `NOP_INSTR`=32'h0, default `RESET_PC`.
- Sub-module `fetch_fifo2`: 2-entry FIFO of {32-bit instr, 32-bit pc} with push/pop/flush, count output, and async active-low reset.
- The top level holds the FSM, `fpc`, and request logic.

## Test plan
- Reset, zero-wait memory, `IFIDWrite`=0: `ImAddr` sequence 3000,3004,3008. Outputs are NOP/0 for 2 cycles, then (instr@3000, PC=3000), (instr@3004, 3004) on consecutive cycles.
- `IFIDWrite`=1 for 5 cycles mid-stream: outputs frozen at (instr@3008, 3008). `ImReq` drops after the FIFO holds 2 entries. Release resumes with 3008, then 300C, without loss.
- Memory with 3 wait states, `Redirect`=1 with `RedirectPC`=32'h0000_3103 during an outstanding fetch of 3010: `ImAddr` holds 3010 until ack, the data is discarded, the next request is 3100, and the first output after the flush is PC=3100.
- `Redirect` at the same edge as `ImAck` and a pop: the popped word reaches IF/ID, the ack data is dropped, and the FIFO is empty next cycle.
- `Reset_n` asserted mid-transfer (between edges): `ImReq`=0, `Instruction`=0, and `PC`=0 immediately. After release, fetching restarts at `RESET_PC`.
- `RedirectPC`=32'hFFFF_FFFC: fetches FFFFFFFC, then 00000000 (wrap).
